// File: rtl/csa_stream_accumulator.sv
// rtl/csa_stream_accumulator.sv - carry-save stream accumulator with chunked resolve
//
// Purpose:
//   Accepts WIDTH-bit unsigned operands on a valid/ready stream and keeps a
//   running total in redundant carry-save form (sum/carry registers) through a
//   per-bit 3:2 compressor, so one operand is absorbed per cycle with no carry
//   chain. On the beat flagged last, the sum/carry pair is resolved by a
//   CHUNK-bit carry-propagate adder over ACC_W/CHUNK cycles, and the binary
//   total is offered on an output valid/ready handshake.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   in_valid   - operand present
//   in_ready   - block can accept an operand (only in ACCUM)
//   in_data    - operand, zero-extended to ACC_W
//   in_last    - final operand of the group, qualified by the handshake
//   out_valid  - resolved result available
//   out_ready  - downstream accepts the result
//   out_sum    - resolved total mod 2^ACC_W
//   out_count  - operands in the group, saturating at 511
//   out_ovf    - group had more than 2^(ACC_W-WIDTH) operands
module csa_stream_accumulator #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 40,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [8:0]       out_count,
    output logic             out_ovf
);

    localparam int NCH    = ACC_W / CHUNK;
    localparam int KW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int OVF_SH = ACC_W - WIDTH;
    // The internal operand counter must be able to exceed the overflow
    // threshold 2^OVF_SH even when that is above the 511 reporting limit.
    localparam int CW     = (OVF_SH + 2 > 9) ? OVF_SH + 2 : 9;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ACC_W-1:0] r_s;
    logic [ACC_W-1:0] r_c;
    logic [ACC_W-1:0] r_res;
    logic [CW-1:0]    r_n;
    logic [KW-1:0]    r_k;
    logic             r_cy;
    logic [8:0]       r_out_count;
    logic             r_out_ovf;

    logic [ACC_W-1:0] w_x;
    logic [ACC_W-1:0] w_maj;
    logic             w_accept;
    logic [CHUNK:0]   w_add;
    logic             w_last_chunk;
    logic [CW-1:0]    w_n_inc;
    logic [8:0]       w_count_sat;
    logic             w_ovf;

    assign w_x      = {{(ACC_W - WIDTH){1'b0}}, in_data};
    assign w_maj    = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);
    assign w_accept = (r_state == ST_ACCUM) && in_valid;

    // Resolve works on the low chunk of S and C; both registers shift right
    // by CHUNK each cycle, and the result fills r_res from the top down, so
    // after NCH cycles chunk k has landed at bit k*CHUNK.
    assign w_add = {1'b0, r_s[CHUNK-1:0]} + {1'b0, r_c[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, r_cy};
    assign w_last_chunk = (r_k == KW'(NCH - 1));

    assign w_n_inc     = (&r_n) ? r_n : r_n + 1'b1;
    assign w_count_sat = (r_n > CW'(511)) ? 9'd511 : r_n[8:0];
    assign w_ovf       = (r_n > (CW'(1) << OVF_SH));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept && in_last) begin
                    w_next = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                if (w_last_chunk) begin
                    w_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    w_next = ST_ACCUM;
                end
            end
            default: w_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s         <= '0;
            r_c         <= '0;
            r_res       <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_cy        <= 1'b0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_s <= r_s ^ r_c ^ w_x;
                        // Carry out of the top bit is dropped: modulo 2^ACC_W.
                        r_c <= {w_maj[ACC_W-2:0], 1'b0};
                        r_n <= w_n_inc;
                        if (in_last) begin
                            r_k  <= '0;
                            r_cy <= 1'b0;
                        end
                    end
                end
                ST_RESOLVE: begin
                    r_res <= {w_add[CHUNK-1:0], r_res[ACC_W-1:CHUNK]};
                    r_s   <= {{CHUNK{1'b0}}, r_s[ACC_W-1:CHUNK]};
                    r_c   <= {{CHUNK{1'b0}}, r_c[ACC_W-1:CHUNK]};
                    r_cy  <= w_add[CHUNK];
                    r_k   <= r_k + 1'b1;
                    if (w_last_chunk) begin
                        r_out_count <= w_count_sat;
                        r_out_ovf   <= w_ovf;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        r_s <= '0;
                        r_c <= '0;
                        r_n <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_OUTPUT);
    assign out_sum   = r_res;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb/tb_csa_stream_accumulator.sv - directed self-checking bench for csa_stream_accumulator
module tb_csa_stream_accumulator;

    localparam int WIDTH = 32;
    localparam int ACC_W = 40;
    localparam int CHUNK = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [8:0]       out_count;
    logic             out_ovf;

    int tests = 0;
    int fails = 0;

    csa_stream_accumulator #(
        .WIDTH(WIDTH),
        .ACC_W(ACC_W),
        .CHUNK(CHUNK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_count(out_count),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic send_beat(input logic [WIDTH-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_out(input string name, output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, lat);
        end
    endtask

    task automatic check_result(input string name, input logic [ACC_W-1:0] esum,
                                input logic [8:0] ecnt, input logic eovf);
        tests++;
        if (out_sum !== esum) begin
            fails++;
            $display("FAIL %s_sum: got 0x%010h, required 0x%010h", name, out_sum, esum);
        end
        tests++;
        if (out_count !== ecnt) begin
            fails++;
            $display("FAIL %s_count: got %0d, required %0d", name, out_count, ecnt);
        end
        tests++;
        if (out_ovf !== eovf) begin
            fails++;
            $display("FAIL %s_ovf: got %b, required %b", name, out_ovf, eovf);
        end
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_after_hs: in_ready=%b out_valid=%b, required 1 0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== 9'd0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset: valid=%b sum=0x%010h count=%0d ovf=%b in_ready=%b, required 0 0 0 0 1",
                     out_valid, out_sum, out_count, out_ovf, in_ready);
        end
    endtask

    task automatic test_single();
        int lat;
        send_beat(32'hFFFF_FFFF, 1'b1);
        wait_out("single", lat);
        tests++;
        if (lat != 6) begin
            fails++;
            $display("FAIL single_latency: got %0d cycles, required 6", lat);
        end
        check_result("single", 40'h00FF_FFFF_FF, 9'd1, 1'b0);
        handshake("single");
    endtask

    task automatic test_three();
        int lat;
        for (int i = 0; i < 3; i++) send_beat(32'hFFFF_FFFF, i == 2);
        wait_out("three_b2b", lat);
        check_result("three_b2b", 40'h02FF_FFFF_FD, 9'd3, 1'b0);
        handshake("three_b2b");
        for (int i = 0; i < 3; i++) begin
            // idle gaps, with a stray last that carries no valid
            in_last = 1'b1;
            repeat (i + 1) @(posedge clk);
            #1;
            in_last = 1'b0;
            send_beat(32'hFFFF_FFFF, i == 2);
        end
        wait_out("three_gaps", lat);
        check_result("three_gaps", 40'h02FF_FFFF_FD, 9'd3, 1'b0);
        handshake("three_gaps");
    endtask

    task automatic test_many();
        int lat;
        for (int i = 0; i < 256; i++) send_beat(32'hFFFF_FFFF, i == 255);
        wait_out("n256", lat);
        check_result("n256", 40'hFF_FFFF_FF00, 9'd256, 1'b0);
        handshake("n256");
        for (int i = 0; i < 257; i++) send_beat(32'hFFFF_FFFF, i == 256);
        wait_out("n257", lat);
        check_result("n257", 40'h00_FFFF_FEFF, 9'd257, 1'b1);
        handshake("n257");
        for (int i = 0; i < 600; i++) send_beat(32'hFFFF_FFFF, i == 599);
        wait_out("n600", lat);
        check_result("n600", 40'h57_FFFF_FDA8, 9'd511, 1'b1);
        handshake("n600");
    endtask

    task automatic test_hold_output();
        int lat;
        for (int i = 0; i < 3; i++) send_beat(32'hFFFF_FFFF, i == 2);
        wait_out("hold", lat);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 40'h02FF_FFFF_FD ||
                out_count !== 9'd3 || out_ovf !== 1'b0) begin
                fails++;
                $display("FAIL hold_stable[%0d]: valid=%b in_ready=%b sum=0x%010h count=%0d ovf=%b, required 1 0 0x02fffffffd 3 0",
                         i, out_valid, in_ready, out_sum, out_count, out_ovf);
            end
        end
        handshake("hold");
        send_beat(32'd5, 1'b0);
        send_beat(32'd7, 1'b1);
        wait_out("cleared", lat);
        check_result("cleared", 40'd12, 9'd2, 1'b0);
        handshake("cleared");
    endtask

    task automatic test_reset_in_resolve();
        int lat;
        send_beat(32'd9, 1'b0);
        send_beat(32'd9, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== 9'd0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset: valid=%b sum=0x%010h count=%0d ovf=%b in_ready=%b, required 0 0 0 0 1",
                     out_valid, out_sum, out_count, out_ovf, in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL mid_reset_no_valid[%0d]: out_valid=%b, required 0", i, out_valid);
            end
        end
        out_ready = 1'b1;
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b1);
        wait_out("after_reset", lat);
        check_result("after_reset", 40'd3, 9'd2, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL early_ready_hs: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_ignore_inputs();
        int lat;
        send_beat(32'h8000_0000, 1'b0);
        send_beat(32'h8000_0000, 1'b1);
        in_valid = 1'b1;
        in_last  = 1'b1;
        lat = 1;
        while (!out_valid && lat < 40) begin
            in_data = (lat % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL ignore_in_ready_resolve[%0d]: in_ready=%b, required 0", lat, in_ready);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hCAFE_F00D ^ i;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL ignore_output_state: out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
        end
        check_result("ignore", 40'h01_0000_0000, 9'd2, 1'b0);
        handshake("ignore");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_three();
        test_many();
        test_hold_output();
        test_reset_in_resolve();
        test_ignore_inputs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
